// File: rtl/fetch_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage_if : instruction-memory, hazard-control and IF/ID bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        stall;
  logic        flush;
  logic [15:0] redirect_pc;
  logic [15:0] pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;

  modport master (
    output imem_req, imem_addr, pc, ifid_instr, ifid_pc_plus2, ifid_valid, halted,
    input  imem_data, imem_valid, stall, flush, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, pc, ifid_instr, ifid_pc_plus2, ifid_valid, halted,
    output imem_data, imem_valid, stall, flush, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage : WISC-S25 instruction fetch (PC, imem request, IF/ID register)
// Optional FETCH_SKID_EN adds a one-entry skid buffer for stalled returns.
// Revision 1.0
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HALT  = 1'b1;

  logic [0:0]  r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_ifid_instr, w_instr_nxt;
  logic [15:0] r_ifid_pp2, w_pp2_nxt;
  logic        r_ifid_valid, w_valid_nxt;
  logic [15:0] w_pc_plus2;
  logic        w_is_hlt;

`ifdef FETCH_SKID_EN
  logic        r_skid_full, w_skid_full_nxt;
  logic [15:0] r_skid_data, w_skid_data_nxt;
  logic [15:0] r_skid_pp2, w_skid_pp2_nxt;
`endif

  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_is_hlt   = (bus.imem_data[15:12] == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pp2   <= 16'h0000;
      r_ifid_valid <= 1'b0;
`ifdef FETCH_SKID_EN
      r_skid_full  <= 1'b0;
      r_skid_data  <= NOP_INSTR;
      r_skid_pp2   <= 16'h0000;
`endif
    end else begin
      r_pc         <= w_pc_nxt;
      r_ifid_instr <= w_instr_nxt;
      r_ifid_pp2   <= w_pp2_nxt;
      r_ifid_valid <= w_valid_nxt;
`ifdef FETCH_SKID_EN
      r_skid_full  <= w_skid_full_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_pp2   <= w_skid_pp2_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_ifid_instr;
    w_pp2_nxt   = r_ifid_pp2;
    w_valid_nxt = r_ifid_valid;
`ifdef FETCH_SKID_EN
    w_skid_full_nxt = r_skid_full;
    w_skid_data_nxt = r_skid_data;
    w_skid_pp2_nxt  = r_skid_pp2;
`endif
    if (bus.flush) begin
      w_pc_nxt    = {bus.redirect_pc[15:1], 1'b0};
      w_state_nxt = S_FETCH;
      w_valid_nxt = 1'b0;
      w_instr_nxt = NOP_INSTR;
`ifdef FETCH_SKID_EN
      w_skid_full_nxt = 1'b0;
`endif
    end else if (bus.stall) begin
`ifdef FETCH_SKID_EN
      // Park the returning word so the stall does not cost a re-fetch.
      if (r_state == S_FETCH && !r_skid_full && bus.imem_valid) begin
        w_skid_full_nxt = 1'b1;
        w_skid_data_nxt = bus.imem_data;
        w_skid_pp2_nxt  = w_pc_plus2;
        if (w_is_hlt) begin
          w_state_nxt = S_HALT;
        end else begin
          w_pc_nxt = w_pc_plus2;
        end
      end
`endif
    end else begin
`ifdef FETCH_SKID_EN
      if (r_skid_full) begin
        w_instr_nxt     = r_skid_data;
        w_pp2_nxt       = r_skid_pp2;
        w_valid_nxt     = 1'b1;
        w_skid_full_nxt = 1'b0;
      end else
`endif
      if (r_state == S_FETCH) begin
        if (bus.imem_valid) begin
          w_instr_nxt = bus.imem_data;
          w_pp2_nxt   = w_pc_plus2;
          w_valid_nxt = 1'b1;
          if (w_is_hlt) begin
            w_state_nxt = S_HALT;
          end else begin
            w_pc_nxt = w_pc_plus2;
          end
        end else begin
          w_instr_nxt = NOP_INSTR;
          w_valid_nxt = 1'b0;
        end
      end
    end
  end

  always_comb begin
`ifdef FETCH_SKID_EN
    bus.imem_req = (r_state == S_FETCH) && !r_skid_full;
`else
    bus.imem_req = (r_state == S_FETCH);
`endif
    bus.halted        = (r_state == S_HALT);
    bus.imem_addr     = r_pc;
    bus.pc            = r_pc;
    bus.ifid_instr    = r_ifid_instr;
    bus.ifid_pc_plus2 = r_ifid_pp2;
    bus.ifid_valid    = r_ifid_valid;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed self-checking bench for fetch_stage
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_fetch_stage;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  fetch_stage_if sif();

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    tests_run++; if (sif.pc !== 16'h0000) begin tests_failed++; $display("FAIL reset_pc: got %h exp 0000", sif.pc); end
    tests_run++; if (sif.ifid_instr !== 16'h0000) begin tests_failed++; $display("FAIL reset_instr: got %h exp 0000", sif.ifid_instr); end
    tests_run++; if (sif.ifid_pc_plus2 !== 16'h0000) begin tests_failed++; $display("FAIL reset_pp2: got %h exp 0000", sif.ifid_pc_plus2); end
    tests_run++; if (sif.ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b exp 0", sif.ifid_valid); end
    tests_run++; if (sif.halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted: got %b exp 0", sif.halted); end
    tests_run++; if (sif.imem_req !== 1'b1) begin tests_failed++; $display("FAIL reset_req: got %b exp 1", sif.imem_req); end
  endtask

  task automatic test_basic();
    rst_n = 1'b1;
    sif.imem_data = 16'h1234; sif.imem_valid = 1'b1;
    #1;
    tests_run++; if (sif.imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL basic_addr: got %h exp 0000", sif.imem_addr); end
    step();
    tests_run++; if (sif.ifid_instr !== 16'h1234) begin tests_failed++; $display("FAIL basic_instr: got %h exp 1234", sif.ifid_instr); end
    tests_run++; if (sif.ifid_pc_plus2 !== 16'h0002) begin tests_failed++; $display("FAIL basic_pp2: got %h exp 0002", sif.ifid_pc_plus2); end
    tests_run++; if (sif.ifid_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b exp 1", sif.ifid_valid); end
    tests_run++; if (sif.pc !== 16'h0002) begin tests_failed++; $display("FAIL basic_pc: got %h exp 0002", sif.pc); end
    sif.imem_valid = 1'b0;
  endtask

  task automatic test_wait_states();
    sif.flush = 1'b1; sif.redirect_pc = 16'h0010;
    step();
    sif.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (sif.pc !== 16'h0010) begin tests_failed++; $display("FAIL wait_pc[%0d]: got %h exp 0010", i, sif.pc); end
      tests_run++; if (sif.ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL wait_valid[%0d]: got %b exp 0", i, sif.ifid_valid); end
    end
    sif.imem_data = 16'hABCD; sif.imem_valid = 1'b1;
    step();
    tests_run++; if (sif.ifid_instr !== 16'hABCD) begin tests_failed++; $display("FAIL wait_instr: got %h exp abcd", sif.ifid_instr); end
    tests_run++; if (sif.ifid_valid !== 1'b1) begin tests_failed++; $display("FAIL wait_done_valid: got %b exp 1", sif.ifid_valid); end
    tests_run++; if (sif.pc !== 16'h0012) begin tests_failed++; $display("FAIL wait_done_pc: got %h exp 0012", sif.pc); end
    sif.imem_valid = 1'b0;
  endtask

  task automatic test_stall();
    sif.imem_data = 16'h5555; sif.imem_valid = 1'b1; sif.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++; if (sif.ifid_instr !== 16'hABCD) begin tests_failed++; $display("FAIL stall_instr[%0d]: got %h exp abcd", i, sif.ifid_instr); end
      tests_run++; if (sif.ifid_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_valid[%0d]: got %b exp 1", i, sif.ifid_valid); end
`ifdef FETCH_SKID_EN
      tests_run++; if (sif.pc !== 16'h0014) begin tests_failed++; $display("FAIL stall_pc[%0d]: got %h exp 0014", i, sif.pc); end
      tests_run++; if (sif.imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_req[%0d]: got %b exp 0", i, sif.imem_req); end
`else
      tests_run++; if (sif.imem_addr !== 16'h0012) begin tests_failed++; $display("FAIL stall_addr[%0d]: got %h exp 0012", i, sif.imem_addr); end
      tests_run++; if (sif.imem_req !== 1'b1) begin tests_failed++; $display("FAIL stall_req[%0d]: got %b exp 1", i, sif.imem_req); end
`endif
    end
    sif.stall = 1'b0;
    step();
    tests_run++; if (sif.ifid_instr !== 16'h5555) begin tests_failed++; $display("FAIL release_instr: got %h exp 5555", sif.ifid_instr); end
    tests_run++; if (sif.ifid_pc_plus2 !== 16'h0014) begin tests_failed++; $display("FAIL release_pp2: got %h exp 0014", sif.ifid_pc_plus2); end
    tests_run++; if (sif.pc !== 16'h0014) begin tests_failed++; $display("FAIL release_pc: got %h exp 0014", sif.pc); end
    sif.imem_valid = 1'b0;
  endtask

  task automatic test_stall_flush();
    sif.stall = 1'b1; sif.flush = 1'b1; sif.redirect_pc = 16'h0041;
    sif.imem_data = 16'h7777; sif.imem_valid = 1'b1;
    step();
    tests_run++; if (sif.pc !== 16'h0040) begin tests_failed++; $display("FAIL sf_pc: got %h exp 0040", sif.pc); end
    tests_run++; if (sif.ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL sf_valid: got %b exp 0", sif.ifid_valid); end
    tests_run++; if (sif.ifid_instr !== 16'h0000) begin tests_failed++; $display("FAIL sf_instr: got %h exp 0000", sif.ifid_instr); end
    sif.stall = 1'b0; sif.flush = 1'b0; sif.imem_valid = 1'b0;
  endtask

  task automatic test_halt();
    sif.flush = 1'b1; sif.redirect_pc = 16'h0020;
    step();
    sif.flush = 1'b0; sif.imem_data = 16'hF000; sif.imem_valid = 1'b1;
    step();
    tests_run++; if (sif.ifid_instr !== 16'hF000) begin tests_failed++; $display("FAIL hlt_instr: got %h exp f000", sif.ifid_instr); end
    tests_run++; if (sif.pc !== 16'h0020) begin tests_failed++; $display("FAIL hlt_pc: got %h exp 0020", sif.pc); end
    tests_run++; if (sif.halted !== 1'b1) begin tests_failed++; $display("FAIL hlt_halted: got %b exp 1", sif.halted); end
    tests_run++; if (sif.imem_req !== 1'b0) begin tests_failed++; $display("FAIL hlt_req: got %b exp 0", sif.imem_req); end
    tests_run++; if (sif.ifid_pc_plus2 !== 16'h0022) begin tests_failed++; $display("FAIL hlt_pp2: got %h exp 0022", sif.ifid_pc_plus2); end
    sif.imem_data = 16'h1111;
    step();
    tests_run++; if (sif.ifid_instr !== 16'hF000) begin tests_failed++; $display("FAIL hlt_hold_instr: got %h exp f000", sif.ifid_instr); end
    tests_run++; if (sif.pc !== 16'h0020) begin tests_failed++; $display("FAIL hlt_hold_pc: got %h exp 0020", sif.pc); end
    sif.flush = 1'b1; sif.redirect_pc = 16'h0030; sif.imem_valid = 1'b0;
    step();
    tests_run++; if (sif.halted !== 1'b0) begin tests_failed++; $display("FAIL unhalt_halted: got %b exp 0", sif.halted); end
    tests_run++; if (sif.pc !== 16'h0030) begin tests_failed++; $display("FAIL unhalt_pc: got %h exp 0030", sif.pc); end
    tests_run++; if (sif.imem_req !== 1'b1) begin tests_failed++; $display("FAIL unhalt_req: got %b exp 1", sif.imem_req); end
    sif.flush = 1'b0; sif.imem_data = 16'h2222; sif.imem_valid = 1'b1;
    step();
    tests_run++; if (sif.ifid_instr !== 16'h2222) begin tests_failed++; $display("FAIL resume_instr: got %h exp 2222", sif.ifid_instr); end
    tests_run++; if (sif.pc !== 16'h0032) begin tests_failed++; $display("FAIL resume_pc: got %h exp 0032", sif.pc); end
    sif.imem_valid = 1'b0;
  endtask

  task automatic test_wrap();
    sif.flush = 1'b1; sif.redirect_pc = 16'hFFFE;
    step();
    sif.flush = 1'b0; sif.imem_data = 16'h3333; sif.imem_valid = 1'b1;
    step();
    tests_run++; if (sif.pc !== 16'h0000) begin tests_failed++; $display("FAIL wrap_pc: got %h exp 0000", sif.pc); end
    tests_run++; if (sif.ifid_pc_plus2 !== 16'h0000) begin tests_failed++; $display("FAIL wrap_pp2: got %h exp 0000", sif.ifid_pc_plus2); end
    tests_run++; if (sif.ifid_instr !== 16'h3333) begin tests_failed++; $display("FAIL wrap_instr: got %h exp 3333", sif.ifid_instr); end
    sif.imem_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    sif.imem_data = 16'h4444; sif.imem_valid = 1'b1;
    sif.flush = 1'b1; sif.redirect_pc = 16'h0100;
    step();
    tests_run++; if (sif.pc !== 16'h0100) begin tests_failed++; $display("FAIL b2b_pc1: got %h exp 0100", sif.pc); end
    tests_run++; if (sif.ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_valid1: got %b exp 0", sif.ifid_valid); end
    sif.redirect_pc = 16'h0200;
    step();
    tests_run++; if (sif.pc !== 16'h0200) begin tests_failed++; $display("FAIL b2b_pc2: got %h exp 0200", sif.pc); end
    tests_run++; if (sif.ifid_instr !== 16'h0000) begin tests_failed++; $display("FAIL b2b_instr2: got %h exp 0000", sif.ifid_instr); end
    sif.flush = 1'b0;
    step();
    tests_run++; if (sif.pc !== 16'h0202) begin tests_failed++; $display("FAIL b2b_pc3: got %h exp 0202", sif.pc); end
    tests_run++; if (sif.ifid_instr !== 16'h4444) begin tests_failed++; $display("FAIL b2b_instr3: got %h exp 4444", sif.ifid_instr); end
    sif.imem_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (sif.pc !== 16'h0000) begin tests_failed++; $display("FAIL arst_pc: got %h exp 0000", sif.pc); end
    tests_run++; if (sif.ifid_pc_plus2 !== 16'h0000) begin tests_failed++; $display("FAIL arst_pp2: got %h exp 0000", sif.ifid_pc_plus2); end
    tests_run++; if (sif.ifid_instr !== 16'h0000) begin tests_failed++; $display("FAIL arst_instr: got %h exp 0000", sif.ifid_instr); end
    tests_run++; if (sif.ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_valid: got %b exp 0", sif.ifid_valid); end
    tests_run++; if (sif.imem_req !== 1'b1) begin tests_failed++; $display("FAIL arst_req: got %b exp 1", sif.imem_req); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b1;
    tests_run = 0;
    tests_failed = 0;
    sif.imem_data = 16'h0000;
    sif.imem_valid = 1'b0;
    sif.stall = 1'b0;
    sif.flush = 1'b0;
    sif.redirect_pc = 16'h0000;
    #2;
    test_reset();
    test_basic();
    test_wait_states();
    test_stall();
    test_stall_flush();
    test_halt();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
`default_nettype wire
